// File: rtl/ascon_pack.sv
// Shared ASCON types, the p12 round count and small helpers for the round datapath.
// No logic of its own: no latency and no backpressure.
package ascon_pack;

    // x0 lives at index 0, x4 at index 4
    typedef logic [4:0][63:0] type_state;
    typedef logic [127:0]     type_key;

    localparam int unsigned P12_ROUNDS = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PERM  = 2'd1,
        FINAL = 2'd2
    } fsm_t;

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // p12 round r uses constant 0xf0, 0xe1, ..., 0x4b
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hf - r, r};
    endfunction

endpackage

// File: rtl/ascon_permutation.sv
// One ASCON round per enabled cycle: input mux, constant add, S-box layer, linear layer, state register.
// Latency: one cycle per round; no backpressure, the caller owns round sequencing through the enable.
module ascon_permutation
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       select_i,
    input  logic       en_reg_state_i,
    input  logic [3:0] round_i,
    input  type_state  state_i,
    output type_state  state_o
);

    type_state mux_s;
    type_state add_s;
    type_state next_s;
    type_state reg_s;

    function automatic type_state sub_layer(input type_state s);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[0] ^ s[4];
        x1 = s[1];
        x2 = s[2] ^ s[1];
        x3 = s[3];
        x4 = s[4] ^ s[3];
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic type_state lin_layer(input type_state s);
        type_state d;
        d[0] = s[0] ^ ror64(s[0], 19) ^ ror64(s[0], 28);
        d[1] = s[1] ^ ror64(s[1], 61) ^ ror64(s[1], 39);
        d[2] = s[2] ^ ror64(s[2], 1)  ^ ror64(s[2], 6);
        d[3] = s[3] ^ ror64(s[3], 10) ^ ror64(s[3], 17);
        d[4] = s[4] ^ ror64(s[4], 7)  ^ ror64(s[4], 41);
        return d;
    endfunction

    // select_i=0 loads a fresh state, select_i=1 iterates on the register
    always_comb begin
        mux_s         = select_i ? reg_s : state_i;
        add_s         = mux_s;
        add_s[2][7:0] = mux_s[2][7:0] ^ round_const(round_i);
        next_s        = lin_layer(sub_layer(add_s));
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            reg_s <= '0;
        end else if (en_reg_state_i) begin
            reg_s <= next_s;
        end
    end

    assign state_o = reg_s;

endmodule

// File: rtl/ascon_final_verify.sv
// ASCON-128 finalization and tag check: key XOR, p12, tag derivation, compare against the received tag.
// Latency: done_o rises 13 edges after start is accepted; start_i is ignored while busy, nothing is queued.
module ascon_final_verify
    import ascon_pack::*;
(
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      start_i,
    input  type_state state_i,
    input  type_key   key_i,
    input  type_key   tag_i,
    output logic      busy_o,
    output logic      done_o,
    output type_key   tag_o,
    output logic      tag_valid_o
);

    localparam logic [3:0] LAST_ROUND = 4'(P12_ROUNDS - 1);

    fsm_t       fsm_q;
    fsm_t       fsm_d;
    logic [3:0] round_q;
    type_state  keyed_s;
    type_state  in_q;
    type_state  perm_s;
    type_key    tag_s;
    type_key    tag_q;
    logic       tag_valid_q;
    logic       done_q;
    logic       accept;
    logic       perm_sel;
    logic       perm_en;
    logic       finish;
    logic       reset_n;

    assign reset_n = ~reset_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (start_i) fsm_d = PERM;
            PERM:    if (round_q == LAST_ROUND) fsm_d = FINAL;
            FINAL:   fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (fsm_q != IDLE);
        accept   = (fsm_q == IDLE) && start_i;
        perm_en  = (fsm_q == PERM);
        perm_sel = (round_q != 4'd0);
        finish   = (fsm_q == FINAL);
    end

    always_comb begin
        keyed_s    = state_i;
        keyed_s[1] = state_i[1] ^ key_i[127:64];
        keyed_s[2] = state_i[2] ^ key_i[63:0];
    end

    // key_i must stay stable for the whole operation: it is reused when forming the tag
    assign tag_s = {perm_s[3] ^ key_i[127:64], perm_s[4] ^ key_i[63:0]};

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            round_q     <= '0;
            in_q        <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                in_q        <= keyed_s;
                round_q     <= '0;
                tag_valid_q <= 1'b0;
            end else if (perm_en && (round_q != LAST_ROUND)) begin
                round_q <= round_q + 4'd1;
            end
            if (finish) begin
                tag_q       <= tag_s;
                tag_valid_q <= (tag_s == tag_i);
                done_q      <= 1'b1;
            end
        end
    end

    ascon_permutation u_perm (
        .clock_i        (clock_i),
        .resetb_i       (reset_n),
        .select_i       (perm_sel),
        .en_reg_state_i (perm_en),
        .round_i        (round_q),
        .state_i        (in_q),
        .state_o        (perm_s)
    );

    assign done_o      = done_q;
    assign tag_o       = tag_q;
    assign tag_valid_o = tag_valid_q;

endmodule

// File: tb/tb_ascon_final_verify.sv
// Self-checking bench for ascon_final_verify against a table-driven ASCON finalization model.
module tb_ascon_final_verify;
    import ascon_pack::*;

    logic         clk;
    logic         reset_i;
    logic         start_i;
    type_state    state_i;
    logic [127:0] key_i;
    logic [127:0] tag_i;
    logic         busy_o;
    logic         done_o;
    logic [127:0] tag_o;
    logic         tag_valid_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] sbox_tbl [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    int rot_a [5] = '{19, 61, 1, 10, 7};
    int rot_b [5] = '{28, 39, 6, 17, 41};

    ascon_final_verify dut (
        .clock_i     (clk),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .state_i     (state_i),
        .key_i       (key_i),
        .tag_i       (tag_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tag_o       (tag_o),
        .tag_valid_o (tag_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [127:0] ref_tag(input type_state s, input logic [127:0] k);
        logic [63:0] x [5];
        logic [63:0] y [5];
        logic [4:0]  v;
        for (int i = 0; i < 5; i++) x[i] = s[i];
        x[1] ^= k[127:64];
        x[2] ^= k[63:0];
        for (int r = 0; r < 12; r++) begin
            x[2] ^= 64'(240 - 15 * r);
            for (int b = 0; b < 64; b++) begin
                v = sbox_tbl[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
                for (int i = 0; i < 5; i++) y[i][b] = v[4 - i];
            end
            for (int i = 0; i < 5; i++) x[i] = y[i] ^ rotr(y[i], rot_a[i]) ^ rotr(y[i], rot_b[i]);
        end
        return {x[3] ^ k[127:64], x[4] ^ k[63:0]};
    endfunction

    function automatic type_state rnd_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    function automatic logic [127:0] rnd_128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Called just after a rising edge; returns edges from acceptance to done (-1 if it never came)
    task automatic run_op(input type_state s, input logic [127:0] k, input logic [127:0] t,
                          output int lat, output logic valid_at_accept);
        state_i = s;
        key_i   = k;
        tag_i   = t;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        valid_at_accept = tag_valid_o;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int           lat;
        int           done_cnt;
        logic         v0;
        logic         match;
        logic [127:0] exp_t;
        logic [127:0] kat_key;
        logic [127:0] t_in;
        type_state    kat_state;
        type_state    s;
        logic [41:0]  done_seen, busy_seen, done_exp, busy_exp;

        reset_i = 1'b1;
        start_i = 1'b0;
        state_i = '0;
        key_i   = '0;
        tag_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 128'(busy_o), 128'(0));
        check("rst_done", 128'(done_o), 128'(0));
        check("rst_tag", tag_o, 128'(0));
        check("rst_valid", 128'(tag_valid_o), 128'(0));
        reset_i = 1'b0;
        @(posedge clk); #1;

        // Known-answer vector with a matching tag
        kat_key   = 128'h000102030405060708090a0b0c0d0e0f;
        kat_state = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
                     64'h8040201008040201, 64'h80400c0600000000};
        exp_t = ref_tag(kat_state, kat_key);
        run_op(kat_state, kat_key, exp_t, lat, v0);
        check("kat_latency", 128'(lat), 128'(13));
        check("kat_tag", tag_o, exp_t);
        check("kat_valid", 128'(tag_valid_o), 128'(1));
        @(posedge clk); #1;
        check("done_one_cycle", 128'(done_o), 128'(0));
        check("idle_after_done", 128'(busy_o), 128'(0));

        // Changing tag_i after completion must not disturb the result
        tag_i = ~exp_t;
        repeat (3) @(posedge clk);
        #1;
        check("valid_hold", 128'(tag_valid_o), 128'(1));
        check("tag_hold", tag_o, exp_t);

        // Same vector, tag bit 0 flipped
        run_op(kat_state, kat_key, exp_t ^ 128'd1, lat, v0);
        check("valid_clr_on_accept", 128'(v0), 128'(0));
        check("flip_latency", 128'(lat), 128'(13));
        check("flip_tag", tag_o, exp_t);
        check("flip_valid", 128'(tag_valid_o), 128'(0));

        // start_i held high: accepts every 14 edges, done every 14 edges from E13
        s       = rnd_state();
        state_i = s;
        key_i   = rnd_128();
        exp_t   = ref_tag(s, key_i);
        tag_i   = exp_t;
        start_i = 1'b1;
        for (int k = 0; k < 42; k++) begin
            @(posedge clk); #1;
            done_seen[k] = done_o;
            busy_seen[k] = busy_o;
            done_exp[k]  = (k % 14 == 13);
            busy_exp[k]  = (k % 14 != 13);
        end
        start_i = 1'b0;
        check("held_done_pattern", 128'(done_seen), 128'(done_exp));
        check("held_busy_pattern", 128'(busy_seen), 128'(busy_exp));
        check("held_tag", tag_o, exp_t);

        // Reset asserted at round 5 aborts the operation with no done pulse
        s = rnd_state();
        state_i = s;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check("abort_busy", 128'(busy_o), 128'(0));
        check("abort_done", 128'(done_o), 128'(0));
        check("abort_tag", tag_o, 128'(0));
        check("abort_valid", 128'(tag_valid_o), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_i  = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done_o) done_cnt++;
        end
        check("abort_no_done", 128'(done_cnt), 128'(0));
        s     = rnd_state();
        key_i = rnd_128();
        exp_t = ref_tag(s, key_i);
        run_op(s, key_i, exp_t, lat, v0);
        check("post_rst_latency", 128'(lat), 128'(13));
        check("post_rst_tag", tag_o, exp_t);
        check("post_rst_valid", 128'(tag_valid_o), 128'(1));

        // Randomized operations, about half with a corrupted tag
        for (int it = 0; it < 8; it++) begin
            s     = rnd_state();
            exp_t = ref_tag(s, kat_key ^ rnd_128());
            key_i = kat_key;
            exp_t = ref_tag(s, key_i);
            match = 1'($urandom_range(0, 1));
            t_in  = match ? exp_t : (exp_t ^ (128'd1 << $urandom_range(0, 127)));
            run_op(s, key_i, t_in, lat, v0);
            check("rnd_latency", 128'(lat), 128'(13));
            check("rnd_tag", tag_o, exp_t);
            check("rnd_valid", 128'(tag_valid_o), 128'(match));
            key_i = rnd_128();
            kat_key = key_i;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ascon_final_verify.md
ASCON_FINAL_VERIFY -- requirements
Module: ascon_final_verify

Interface
REQ-001 SHALL have port clock_i, input, 1 bit: single clock, all state updates on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start_i, input, 1 bit: request to finalize; sampled only in IDLE.
REQ-004 SHALL have port state_i, input, type_state (5x64): ASCON state after the last ciphertext block.
REQ-005 SHALL have port key_i, input, 128 bits: K, with K[127:64] the high word.
REQ-006 SHALL have port tag_i, input, 128 bits: received tag to be checked.
REQ-007 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done_o, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 SHALL have port tag_o, output, 128 bits: computed tag.
REQ-010 SHALL have port tag_valid_o, output, 1 bit: high when tag_o equals tag_i.

Function
REQ-011 SHALL implement ASCON-128 finalization: x1^=K[127:64], x2^=K[63:0], then p12, then T={x3^K[127:64], x4^K[63:0]}.
REQ-012 SHALL use FSM states IDLE, PERM, FINAL.
REQ-013 In IDLE with start_i=1 at edge E0: SHALL register state_i with the key XOR applied into an input register, clear tag_valid_o, clear the round counter to 0, and go to PERM.
REQ-014 In PERM: SHALL apply one round per cycle, rounds 0..11 (p12 constants), with permutation data_sel=0 at round 0 and 1 otherwise; the state register is enabled in every PERM cycle.
REQ-015 At the edge where round=11 completes (E12): SHALL go to FINAL.
REQ-016 In FINAL: SHALL compute T combinationally from the permutation output; at E13 it SHALL register tag_o, set tag_valid_o=(T==tag_i), pulse done_o for exactly one cycle, and return to IDLE.
REQ-017 Latency: SHALL be exactly 13 cycles from the start-accept edge to the edge that asserts done_o.
REQ-018 SHALL ignore start_i in PERM and FINAL, with no queuing.
REQ-019 A start_i held high through the E13 edge SHALL NOT be accepted at E13; it SHALL first be accepted at E14.
REQ-020 SHALL compare tag_i in the FINAL cycle only; later changes on tag_i SHALL NOT alter tag_valid_o.
REQ-021 tag_o and tag_valid_o SHALL hold their values until the next start is accepted, or until reset.
REQ-022 The round counter SHALL be 4 bits and SHALL NOT wrap within an operation.

Reset
REQ-023 On reset_i=1, at any time including mid-PERM: the FSM SHALL go to IDLE, with round=0, the state register and input register cleared, busy_o=0, done_o=0, tag_o=0, tag_valid_o=0.
REQ-024 SHALL not generate a done_o pulse for an operation aborted by reset; after reset release, the first accepted start SHALL behave as in REQ-013.
REQ-025 Existing sub-modules that use active-low resets SHALL receive the inverted reset_i.

Structure
REQ-026 type_state and the p12 round count (12) SHALL live in ascon_pack; a 128-bit key/tag type SHALL be added to ascon_pack.
REQ-027 SHALL reuse the existing permutation module as its only sub-module; the FSM, round counter, key XOR and tag compare are local.

Verification
REQ-028 KAT: key_i=000102..0F, state_i and tag_i from the golden C model, start pulse -> done_o at the 13th edge after acceptance, tag_o equals the model tag, tag_valid_o=1.
REQ-029 Same vector with tag_i bit 0 flipped -> identical tag_o, tag_valid_o=0.
REQ-030 start_i held high continuously -> accepts at E0, E14, E28, ...; done_o pulses at E13, E27, ...; busy_o low only in the cycle after each done.
REQ-031 reset_i asserted at round 5 -> all outputs 0 immediately with no done_o pulse; a new start after release gives the correct tag at +13 edges.
REQ-032 tag_i changed after done_o -> tag_valid_o unchanged until the next start is accepted, at which point it clears to 0.
